factorial_core: RTL and testbench
=================================

// Module: factorial_core
// PURPOSE
//  Parametrised, registered factorial engine: computes N! for an OP_W-bit operand
//  into a DATA_W-bit result, with sticky overflow detection and early termination.
//  Control is a 3-state INIT/MULT/DONE FSM; each factor is applied by an internal
//  shift-add multiplier, one multiplier bit per cycle.
//  Sits behind the system's start/clear control interface; result is read in DONE.
// PARAMETERS
//  DATA_W  64  result/accumulator width (bits)
//  OP_W    8   operand width; also the number of cycles per multiply step
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  op_start   in   1       start request, sampled in INIT only
//  op_clear   in   1       synchronous abort/clear, honoured in every state
//  operand    in   OP_W    N, captured on the edge that accepts op_start
//  result     out  DATA_W  N! (low DATA_W bits); 0 outside DONE
//  op_done    out  1       high while state==DONE
//  op_busy    out  1       high while state==MULT
//  overflow   out  1       sticky; the true product exceeded DATA_W bits
//  state      out  2       INIT=2'b00, MULT=2'b01, DONE=2'b10 (2'b11 unused)
// BEHAVIOUR
//  - reset_n low: state=INIT, result=0, op_done=0, op_busy=0, overflow=0,
//    internal acc=1, n=0, bit index k=0. Reset mid-operation discards all work.
//  - All outputs are registered; none is combinationally derived from an input.
//  - op_clear=1 has priority over everything: next edge -> INIT,
//    result=0, overflow=0, acc=1.
//  - INIT: if op_start=1 and op_clear=0: n<=operand, acc<=1, k<=0, overflow<=0.
//      operand<=1 -> DONE next edge with result=1 (0! = 1! = 1).
//      otherwise  -> MULT. op_start=0: stay in INIT.
//  - MULT: each cycle, partial (DATA_W+OP_W bits) += n[k] ? (acc<<k) : 0; k<=k+1.
//      When k==OP_W-1, the multiply step completes on that edge:
//        acc<=partial[DATA_W-1:0]; partial<=0; k<=0; n<=n-1.
//        partial[DATA_W+OP_W-1:DATA_W]!=0 -> overflow<=1, result<=truncated
//          product, -> DONE (early termination).
//        else n==2 -> result<=product, -> DONE. else stay in MULT.
//      Factors are applied in the order N, N-1, ..., 2: N-1 steps of OP_W
//      cycles each. Latency: op_done rises (N-1)*OP_W edges after the accepting
//      edge when there is no overflow.
//  - DONE: result, overflow held; op_start ignored; leave only via op_clear
//    (-> INIT next edge).
//  - op_start during MULT or DONE: ignored; no restart without op_clear.
//  - Illegal state 2'b11: recover to INIT on next edge with INIT output values.
// TESTING (DATA_W=64, OP_W=8)
//  1. reset, operand=5, pulse op_start -> op_busy=1 for 32 cycles, then
//     op_done=1, result=120, overflow=0; held until op_clear.
//  2. operand=0, then operand=1 -> DONE one edge after the accepting edge,
//     result=1, op_busy never asserted.
//  3. operand=20 -> result=2432902008176640000, overflow=0, done after 152 edges.
//  4. operand=21 -> overflow on the x3 step: DONE after 152 edges,
//     result=7098727012145168384, overflow=1.
//  5. operand=10, assert op_clear at edge 20 together with op_start -> INIT next
//     edge, result=0, overflow=0. op_start while busy/done is ignored.
//  6. reset_n asserted asynchronously mid-MULT (between clock edges) -> all outputs
//     are 0 immediately. After release, a fresh operand=3 gives result=6 in 16 edges.

Source files
------------

// File: rtl/factorial_core_if.sv
// Start/clear control interface of the factorial engine: requests in, result and status out.
interface factorial_core_if #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 8
);
  logic              op_start;
  logic              op_clear;
  logic [OP_W-1:0]   operand;
  logic [DATA_W-1:0] result;
  logic              op_done;
  logic              op_busy;
  logic              overflow;
  logic [1:0]        state;

  modport master (
    output op_start, op_clear, operand,
    input  result, op_done, op_busy, overflow, state
  );

  modport slave (
    input  op_start, op_clear, operand,
    output result, op_done, op_busy, overflow, state
  );
endinterface

// File: rtl/factorial_core.sv
// Registered N! engine: INIT/MULT/DONE FSM driving a bit-serial shift-add multiplier
// (one multiplier bit per cycle) with sticky overflow and early termination.
module factorial_core #(
   parameter int DATA_W = 64,
   parameter int OP_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   factorial_core_if.slave  bus
);

   localparam int P_W = DATA_W + OP_W;
   localparam int K_W = (OP_W > 1) ? $clog2(OP_W) : 1;

   typedef enum logic [1:0] {
      S_INIT = 2'b00,
      S_MULT = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_acc;
   logic [P_W-1:0]    r_partial;
   logic [OP_W-1:0]   r_n;
   logic [K_W-1:0]    r_k;
   logic [DATA_W-1:0] r_result;
   logic              r_overflow;
   logic              r_done;
   logic              r_busy;

   logic [P_W-1:0]    w_addend;
   logic [P_W-1:0]    w_partial_next;
   logic              w_step_ovf;
   logic              w_last_bit;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_addend = '0;
      if (r_n[r_k]) begin
         w_addend = {{OP_W{1'b0}}, r_acc} << r_k;
      end
      w_partial_next = r_partial + w_addend;
      w_step_ovf     = |w_partial_next[P_W-1:DATA_W];
      w_last_bit     = (r_k == K_W'(OP_W - 1));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_INIT;
         r_acc      <= DATA_W'(1);
         r_partial  <= '0;
         r_n        <= '0;
         r_k        <= '0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else if (bus.op_clear) begin
         r_state    <= S_INIT;
         r_acc      <= DATA_W'(1);
         r_partial  <= '0;
         r_k        <= '0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               if (bus.op_start) begin
                  r_n        <= bus.operand;
                  r_acc      <= DATA_W'(1);
                  r_partial  <= '0;
                  r_k        <= '0;
                  r_overflow <= 1'b0;
                  if (bus.operand <= OP_W'(1)) begin
                     r_state  <= S_DONE;
                     r_result <= DATA_W'(1);
                     r_done   <= 1'b1;
                  end else begin
                     r_state <= S_MULT;
                     r_busy  <= 1'b1;
                  end
               end
            end

            S_MULT: begin
               if (w_last_bit) begin
                  r_acc     <= w_partial_next[DATA_W-1:0];
                  r_partial <= '0;
                  r_k       <= '0;
                  r_n       <= r_n - OP_W'(1);
                  // Overflow stops the chain early; the truncated product is kept.
                  if (w_step_ovf || r_n == OP_W'(2)) begin
                     r_overflow <= w_step_ovf;
                     r_result   <= w_partial_next[DATA_W-1:0];
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_busy     <= 1'b0;
                  end
               end else begin
                  r_partial <= w_partial_next;
                  r_k       <= r_k + K_W'(1);
               end
            end

            S_DONE: ;

            default: begin
               r_state    <= S_INIT;
               r_acc      <= DATA_W'(1);
               r_partial  <= '0;
               r_k        <= '0;
               r_result   <= '0;
               r_overflow <= 1'b0;
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.result   = r_result;
   assign bus.op_done  = r_done;
   assign bus.op_busy  = r_busy;
   assign bus.overflow = r_overflow;
   assign bus.state    = r_state;

endmodule

// File: tb/tb_factorial_core.sv
// Directed self-checking bench for factorial_core (DATA_W=64, OP_W=8).
module tb_factorial_core;

   logic clk;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;
   int   edges;
   int   busy_cycles;

   factorial_core_if #(.DATA_W(64), .OP_W(8)) bus ();

   factorial_core #(.DATA_W(64), .OP_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edges after the accepting edge until op_done, bounded; counts busy samples.
   task automatic wait_done(output int n_edges, output int n_busy);
      n_edges = 0;
      n_busy  = 0;
      while (!bus.op_done && n_edges < 400) begin
         if (bus.op_busy) n_busy++;
         tick();
         n_edges++;
      end
   endtask

   task automatic start(input logic [7:0] n);
      bus.operand  = n;
      bus.op_start = 1'b1;
      tick();
      bus.op_start = 1'b0;
   endtask

   task automatic clear();
      bus.op_clear = 1'b1;
      tick();
      bus.op_clear = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      bus.op_start = 1'b0;
      bus.op_clear = 1'b0;
      bus.operand  = '0;
      #23;
      check("reset_result",   bus.result,   64'd0);
      check("reset_done",     bus.op_done,  64'd0);
      check("reset_busy",     bus.op_busy,  64'd0);
      check("reset_overflow", bus.overflow, 64'd0);
      check("reset_state",    bus.state,    64'd0);
      reset_n = 1'b1;
      tick();

      // 5! = 120, 4 steps x 8 cycles
      start(8'd5);
      check("n5_busy_after_accept", bus.op_busy, 64'd1);
      check("n5_state_mult",        bus.state,   64'd1);
      wait_done(edges, busy_cycles);
      check("n5_latency",     edges,        64'd32);
      check("n5_busy_cycles", busy_cycles,  64'd32);
      check("n5_result",      bus.result,   64'd120);
      check("n5_overflow",    bus.overflow, 64'd0);
      check("n5_state_done",  bus.state,    64'd2);
      check("n5_busy_low",    bus.op_busy,  64'd0);
      repeat (5) tick();
      check("n5_held", bus.result, 64'd120);
      clear();
      check("n5_clear_result", bus.result,  64'd0);
      check("n5_clear_state",  bus.state,   64'd0);
      check("n5_clear_done",   bus.op_done, 64'd0);

      // 0! and 1! finish one edge after acceptance
      start(8'd0);
      check("n0_done",   bus.op_done, 64'd1);
      check("n0_result", bus.result,  64'd1);
      check("n0_busy",   bus.op_busy, 64'd0);
      clear();
      start(8'd1);
      check("n1_done",   bus.op_done, 64'd1);
      check("n1_result", bus.result,  64'd1);
      check("n1_busy",   bus.op_busy, 64'd0);
      clear();

      // 20! is the largest that fits in 64 bits
      start(8'd20);
      wait_done(edges, busy_cycles);
      check("n20_latency",  edges,        64'd152);
      check("n20_result",   bus.result,   64'd2432902008176640000);
      check("n20_overflow", bus.overflow, 64'd0);
      clear();

      // 21: overflow on the x3 step, truncated 21!/2
      start(8'd21);
      wait_done(edges, busy_cycles);
      check("n21_latency",  edges,        64'd152);
      check("n21_result",   bus.result,   64'd7098727012145168384);
      check("n21_overflow", bus.overflow, 64'd1);
      check("n21_state",    bus.state,    64'd2);
      clear();
      check("n21_clear_overflow", bus.overflow, 64'd0);
      check("n21_clear_result",   bus.result,   64'd0);

      // clear wins over start mid-MULT
      start(8'd10);
      repeat (19) tick();
      check("n10_busy_mid", bus.op_busy, 64'd1);
      bus.op_clear = 1'b1;
      bus.op_start = 1'b1;
      tick();
      bus.op_clear = 1'b0;
      bus.op_start = 1'b0;
      check("n10_clear_state",    bus.state,    64'd0);
      check("n10_clear_result",   bus.result,   64'd0);
      check("n10_clear_overflow", bus.overflow, 64'd0);
      check("n10_clear_busy",     bus.op_busy,  64'd0);

      // asynchronous reset between edges mid-MULT
      start(8'd7);
      repeat (5) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_busy",   bus.op_busy,  64'd0);
      check("areset_state",  bus.state,    64'd0);
      check("areset_done",   bus.op_done,  64'd0);
      check("areset_result", bus.result,   64'd0);
      #3;
      reset_n = 1'b1;
      tick();

      // fresh 3! = 6; op_start held high with another operand throughout is ignored
      start(8'd3);
      bus.operand  = 8'd9;
      bus.op_start = 1'b1;
      wait_done(edges, busy_cycles);
      check("n3_latency", edges,      64'd16);
      check("n3_result",  bus.result, 64'd6);
      repeat (4) tick();
      check("n3_done_held_start", bus.op_done, 64'd1);
      check("n3_result_held",     bus.result,  64'd6);
      bus.op_start = 1'b0;
      clear();
      check("n3_clear_state", bus.state, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
